// File: rtl/arith_ctrl_pkg.sv
// Shared constants for the two-requester arithmetic engine: data width,
// opcode encodings and the controller state type.
package arith_ctrl_pkg;

  localparam int DATA_W = 8;

  localparam logic [2:0] OP_OR   = 3'b000;
  localparam logic [2:0] OP_NAND = 3'b001;
  localparam logic [2:0] OP_NOR  = 3'b010;
  localparam logic [2:0] OP_AND  = 3'b011;
  localparam logic [2:0] OP_ADD  = 3'b100;
  localparam logic [2:0] OP_SUB  = 3'b101;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

endpackage

// File: rtl/arith_ctrl_alu.sv
// Combinational opcode/operand datapath; unused opcodes yield zero and
// ADD/SUB wrap modulo 2^DATA_W.
module arith_ctrl_alu
  import arith_ctrl_pkg::*;
(
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  input  logic [2:0]        op,
  output logic [DATA_W-1:0] result
);

  always_comb begin
    result = '0;
    case (op)
      OP_OR:   result = a | b;
      OP_NAND: result = ~(a & b);
      OP_NOR:  result = ~(a | b);
      OP_AND:  result = a & b;
      OP_ADD:  result = a + b;
      OP_SUB:  result = a - b;
      default: result = '0;
    endcase
  end

endmodule

// File: rtl/arith_engine_arbiter.sv
// Two-requester arithmetic engine: arbiter, IDLE/EXEC/RESP controller and
// operand/result registers. Define ARITH_ARB_ROUND_ROBIN_EN for round-robin ties.
module arith_engine_arbiter
  import arith_ctrl_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid_0,
  output logic              req_ready_0,
  input  logic [DATA_W-1:0] req_a_0,
  input  logic [DATA_W-1:0] req_b_0,
  input  logic [2:0]        req_op_0,
  output logic              rsp_valid_0,
  output logic [DATA_W-1:0] rsp_result_0,
  input  logic              rsp_ready_0,
  input  logic              req_valid_1,
  output logic              req_ready_1,
  input  logic [DATA_W-1:0] req_a_1,
  input  logic [DATA_W-1:0] req_b_1,
  input  logic [2:0]        req_op_1,
  output logic              rsp_valid_1,
  output logic [DATA_W-1:0] rsp_result_1,
  input  logic              rsp_ready_1,
  output logic              busy
);

  state_t            state, next_state;
  logic              grant;
  logic              accept;
  logic              owner_q;
  logic [DATA_W-1:0] a_q, b_q, result_q;
  logic [2:0]        op_q;
  logic [DATA_W-1:0] alu_result;

`ifdef ARITH_ARB_ROUND_ROBIN_EN
  logic rr_ptr;

  // The pointer only matters on a tie; a lone requester always wins.
  always_comb begin
    grant = 1'b0;
    if (req_valid_0 && req_valid_1) grant = rr_ptr;
    else                            grant = !req_valid_0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)         rr_ptr <= 1'b0;
    else if (accept) rr_ptr <= !grant;
  end
`else
  always_comb begin
    grant = !req_valid_0;
  end
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= next_state;
  end

  always_comb begin
    next_state   = state;
    req_ready_0  = 1'b0;
    req_ready_1  = 1'b0;
    rsp_valid_0  = 1'b0;
    rsp_valid_1  = 1'b0;
    rsp_result_0 = '0;
    rsp_result_1 = '0;
    busy         = (state != IDLE);
    case (state)
      IDLE: begin
        // Ready is held low while reset is asserted so nothing looks accepted.
        req_ready_0 = !rst && req_valid_0 && !grant;
        req_ready_1 = !rst && req_valid_1 && grant;
        if (req_ready_0 || req_ready_1) next_state = EXEC;
      end
      EXEC: next_state = RESP;
      RESP: begin
        if (!owner_q) begin
          rsp_valid_0  = 1'b1;
          rsp_result_0 = result_q;
          if (rsp_ready_0) next_state = IDLE;
        end else begin
          rsp_valid_1  = 1'b1;
          rsp_result_1 = result_q;
          if (rsp_ready_1) next_state = IDLE;
        end
      end
      default: next_state = IDLE;
    endcase
  end

  assign accept = req_ready_0 || req_ready_1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_q      <= '0;
      b_q      <= '0;
      op_q     <= '0;
      owner_q  <= 1'b0;
      result_q <= '0;
    end else begin
      if (accept) begin
        a_q     <= grant ? req_a_1  : req_a_0;
        b_q     <= grant ? req_b_1  : req_b_0;
        op_q    <= grant ? req_op_1 : req_op_0;
        owner_q <= grant;
      end
      if (state == EXEC) result_q <= alu_result;
    end
  end

  arith_ctrl_alu u_alu (
    .a      (a_q),
    .b      (b_q),
    .op     (op_q),
    .result (alu_result)
  );

endmodule

// File: tb/tb_arith_engine_arbiter.sv
// Directed bench for arith_engine_arbiter: vector table of single operations
// plus hand sequences for arbitration, response back-pressure and reset abort.
module tb_arith_engine_arbiter;

  logic       clk = 1'b0;
  logic       rst;
  logic       req_valid_0, req_ready_0, rsp_valid_0, rsp_ready_0;
  logic       req_valid_1, req_ready_1, rsp_valid_1, rsp_ready_1;
  logic [7:0] req_a_0, req_b_0, rsp_result_0;
  logic [7:0] req_a_1, req_b_1, rsp_result_1;
  logic [2:0] req_op_0, req_op_1;
  logic       busy;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic       sel;
    logic [7:0] a;
    logic [7:0] b;
    logic [2:0] op;
    logic [7:0] expected;
  } vec_t;

  vec_t vecs[10];

  arith_engine_arbiter dut (
    .clk          (clk),
    .rst          (rst),
    .req_valid_0  (req_valid_0),
    .req_ready_0  (req_ready_0),
    .req_a_0      (req_a_0),
    .req_b_0      (req_b_0),
    .req_op_0     (req_op_0),
    .rsp_valid_0  (rsp_valid_0),
    .rsp_result_0 (rsp_result_0),
    .rsp_ready_0  (rsp_ready_0),
    .req_valid_1  (req_valid_1),
    .req_ready_1  (req_ready_1),
    .req_a_1      (req_a_1),
    .req_b_1      (req_b_1),
    .req_op_1     (req_op_1),
    .rsp_valid_1  (rsp_valid_1),
    .rsp_result_1 (rsp_result_1),
    .rsp_ready_1  (rsp_ready_1),
    .busy         (busy)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [7:0] actual,
                             input logic [7:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got %h expected %h", name, actual, expected);
    end
  endtask

  // Caller is at a negedge with the engine idle; returns at a negedge, idle again.
  task automatic applyStimulus(input vec_t v, input string name);
    req_valid_0 = 1'b0;
    req_valid_1 = 1'b0;
    if (v.sel) begin
      req_valid_1 = 1'b1; req_a_1 = v.a; req_b_1 = v.b; req_op_1 = v.op;
    end else begin
      req_valid_0 = 1'b1; req_a_0 = v.a; req_b_0 = v.b; req_op_0 = v.op;
    end
    #1;
    checkOutput({name, " req_ready_0"}, {7'b0, req_ready_0}, {7'b0, !v.sel});
    checkOutput({name, " req_ready_1"}, {7'b0, req_ready_1}, {7'b0, v.sel});
    @(negedge clk);
    req_valid_0 = 1'b0;
    req_valid_1 = 1'b0;
    checkOutput({name, " exec busy"}, {7'b0, busy}, 8'h01);
    checkOutput({name, " exec rsp_valid"}, {6'b0, rsp_valid_1, rsp_valid_0}, 8'h00);
    checkOutput({name, " exec result0"}, rsp_result_0, 8'h00);
    @(negedge clk);
    if (v.sel) begin
      checkOutput({name, " rsp_valid"}, {6'b0, rsp_valid_1, rsp_valid_0}, 8'h02);
      checkOutput({name, " result"}, rsp_result_1, v.expected);
      checkOutput({name, " other result"}, rsp_result_0, 8'h00);
      rsp_ready_1 = 1'b1;
    end else begin
      checkOutput({name, " rsp_valid"}, {6'b0, rsp_valid_1, rsp_valid_0}, 8'h01);
      checkOutput({name, " result"}, rsp_result_0, v.expected);
      checkOutput({name, " other result"}, rsp_result_1, 8'h00);
      rsp_ready_0 = 1'b1;
    end
    @(negedge clk);
    rsp_ready_0 = 1'b0;
    rsp_ready_1 = 1'b0;
    checkOutput({name, " idle busy"}, {7'b0, busy}, 8'h00);
    checkOutput({name, " idle rsp_valid"}, {6'b0, rsp_valid_1, rsp_valid_0}, 8'h00);
  endtask

  task automatic pulseReset();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    vec_t v;
    logic [7:0] exp_grant;
    vecs[0] = '{1'b0, 8'h0F, 8'h01, 3'b100, 8'h10};
    vecs[1] = '{1'b1, 8'h0F, 8'h01, 3'b101, 8'h0E};
    vecs[2] = '{1'b1, 8'hAA, 8'hCC, 3'b001, 8'h77};
    vecs[3] = '{1'b1, 8'hAA, 8'hCC, 3'b010, 8'h11};
    vecs[4] = '{1'b0, 8'h5A, 8'h3C, 3'b110, 8'h00};
    vecs[5] = '{1'b0, 8'hFF, 8'h01, 3'b100, 8'h00};
    vecs[6] = '{1'b1, 8'h00, 8'h01, 3'b101, 8'hFF};
    vecs[7] = '{1'b0, 8'h0F, 8'hF0, 3'b000, 8'hFF};
    vecs[8] = '{1'b1, 8'hAA, 8'hCC, 3'b011, 8'h88};
    vecs[9] = '{1'b0, 8'hFF, 8'hFF, 3'b111, 8'h00};

    rst = 1'b1;
    req_valid_0 = 1'b1; req_a_0 = 8'h00; req_b_0 = 8'h00; req_op_0 = 3'b000;
    req_valid_1 = 1'b0; req_a_1 = 8'h00; req_b_1 = 8'h00; req_op_1 = 3'b000;
    rsp_ready_0 = 1'b0; rsp_ready_1 = 1'b0;
    repeat (2) @(negedge clk);
    checkOutput("reset req_ready_0", {7'b0, req_ready_0}, 8'h00);
    checkOutput("reset busy", {7'b0, busy}, 8'h00);
    checkOutput("reset rsp_valid", {6'b0, rsp_valid_1, rsp_valid_0}, 8'h00);
    checkOutput("reset result0", rsp_result_0, 8'h00);
    checkOutput("reset result1", rsp_result_1, 8'h00);
    req_valid_0 = 1'b0;
    rst = 1'b0;

    // First vector is accepted at the very first edge after reset release.
    for (int i = 0; i < 10; i++) begin
      applyStimulus(vecs[i], $sformatf("vec%0d", i));
    end

    // Both requesters valid continuously; responses taken immediately.
    pulseReset();
    req_valid_0 = 1'b1; req_a_0 = 8'h0F; req_b_0 = 8'hF0; req_op_0 = 3'b000;
    req_valid_1 = 1'b1; req_a_1 = 8'h0F; req_b_1 = 8'hF0; req_op_1 = 3'b000;
    rsp_ready_0 = 1'b1; rsp_ready_1 = 1'b1;
    for (int k = 0; k < 4; k++) begin
`ifdef ARITH_ARB_ROUND_ROBIN_EN
      exp_grant = (k % 2 == 1) ? 8'h01 : 8'h00;
`else
      exp_grant = 8'h00;
`endif
      #1;
      checkOutput($sformatf("arb%0d req_ready_0", k), {7'b0, req_ready_0},
                  (exp_grant == 8'h00) ? 8'h01 : 8'h00);
      checkOutput($sformatf("arb%0d req_ready_1", k), {7'b0, req_ready_1}, exp_grant);
      repeat (2) @(negedge clk);
      checkOutput($sformatf("arb%0d rsp_valid", k), {6'b0, rsp_valid_1, rsp_valid_0},
                  (exp_grant == 8'h00) ? 8'h01 : 8'h02);
      checkOutput($sformatf("arb%0d result", k),
                  (exp_grant == 8'h00) ? rsp_result_0 : rsp_result_1, 8'hFF);
      @(negedge clk);
    end
    req_valid_0 = 1'b0; req_valid_1 = 1'b0;
    rsp_ready_0 = 1'b0; rsp_ready_1 = 1'b0;
    pulseReset();

    // Response back-pressure on requester 0 while requester 1 waits.
    req_valid_0 = 1'b1; req_a_0 = 8'h0F; req_b_0 = 8'h01; req_op_0 = 3'b100;
    req_valid_1 = 1'b1; req_a_1 = 8'h0F; req_b_1 = 8'h01; req_op_1 = 3'b101;
    @(negedge clk);
    req_valid_0 = 1'b0;
    @(negedge clk);
    for (int c = 0; c < 5; c++) begin
      checkOutput($sformatf("stall%0d rsp_valid_0", c), {7'b0, rsp_valid_0}, 8'h01);
      checkOutput($sformatf("stall%0d result", c), rsp_result_0, 8'h10);
      checkOutput($sformatf("stall%0d req_ready_1", c), {7'b0, req_ready_1}, 8'h00);
      checkOutput($sformatf("stall%0d busy", c), {7'b0, busy}, 8'h01);
      @(negedge clk);
    end
    rsp_ready_0 = 1'b1;
    @(negedge clk);
    rsp_ready_0 = 1'b0;
    checkOutput("stall release req_ready_1", {7'b0, req_ready_1}, 8'h01);
    v = '{1'b1, 8'h0F, 8'h01, 3'b101, 8'h0E};
    applyStimulus(v, "held req1");

    // Reset while the operation is executing aborts it.
    req_valid_0 = 1'b1; req_a_0 = 8'h0F; req_b_0 = 8'h01; req_op_0 = 3'b100;
    rsp_ready_0 = 1'b1;
    @(negedge clk);
    req_valid_0 = 1'b0;
    checkOutput("pre-abort busy", {7'b0, busy}, 8'h01);
    rst = 1'b1;
    #1;
    checkOutput("abort busy", {7'b0, busy}, 8'h00);
    checkOutput("abort rsp_valid", {6'b0, rsp_valid_1, rsp_valid_0}, 8'h00);
    checkOutput("abort result0", rsp_result_0, 8'h00);
    @(negedge clk);
    rst = 1'b0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      checkOutput($sformatf("post-abort%0d rsp_valid", c),
                  {6'b0, rsp_valid_1, rsp_valid_0}, 8'h00);
      checkOutput($sformatf("post-abort%0d busy", c), {7'b0, busy}, 8'h00);
    end
    rsp_ready_0 = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/arith_engine_arbiter.md
ARITH_ENGINE_ARBITER -- requirements
Module: arith_engine_arbiter

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-high reset: clk input 1, rising-edge clock; rst input 1, asynchronous active-high reset.
REQ-002 The block SHALL provide, for i in {0,1}: req_valid_i input 1, request pending.
REQ-003 req_ready_i output 1 SHALL indicate that the request is accepted this cycle.
REQ-004 req_a_i input 8 SHALL carry operand A.
REQ-005 req_b_i input 8 SHALL carry operand B.
REQ-006 req_op_i input 3 SHALL carry the opcode.
REQ-007 rsp_valid_i output 1 SHALL indicate that a result is pending for requester i.
REQ-008 rsp_result_i output 8 SHALL carry the result.
REQ-009 rsp_ready_i input 1 SHALL indicate that requester i takes the result.
REQ-010 busy output 1 SHALL be high whenever the state is not IDLE.

Function
REQ-011 The FSM SHALL have exactly three states: IDLE, EXEC, RESP.
REQ-012 In IDLE, the block SHALL assert req_ready_g combinationally for the granted requester g only, and only when req_valid_g=1; the other req_ready SHALL stay 0.
REQ-013 Handshake: a request is accepted when valid and ready are both high at a clk edge; operands, opcode and owner g SHALL then be latched and the state SHALL go IDLE->EXEC.
REQ-014 In EXEC, the datapath SHALL compute from the latched operands, latch the result at the edge, and go EXEC->RESP.
REQ-015 Opcodes SHALL be: 000 OR, 001 NAND, 010 NOR, 011 AND, 100 ADD, 101 SUB; 110/111 SHALL yield 8'h00.
REQ-016 ADD/SUB SHALL be 8-bit modulo 256 with carry/borrow discarded (8'hFF+8'h01=8'h00; 8'h00-8'h01=8'hFF).
REQ-017 In RESP, rsp_valid_g SHALL be 1 with rsp_result_g stable until rsp_ready_g=1 at an edge; the state SHALL then go RESP->IDLE.
REQ-018 The non-owner's rsp_valid SHALL be 0 at all times.
REQ-019 Minimum latency SHALL be: accept at edge N, rsp_valid high from after edge N+1, earliest next accept at edge N+3; throughput SHALL be at most one operation per 3 cycles.
REQ-020 Requests arriving during EXEC/RESP SHALL see req_ready=0 and SHALL be held by the requester; none SHALL be dropped or queued internally.
REQ-021 rsp_result_i SHALL be 8'h00 whenever rsp_valid_i=0.
REQ-022 Simultaneous req_valid_0 and req_valid_1 in IDLE SHALL be resolved per REQ-026/REQ-027; exactly one SHALL be accepted.

Reset
REQ-023 On rst=1, asynchronously: state SHALL be IDLE; all req_ready, rsp_valid and busy SHALL be 0; all rsp_result SHALL be 8'h00; the latched operand/result registers SHALL be 0; the round-robin pointer SHALL be 0 (requester 0 preferred).
REQ-024 Reset during EXEC or RESP SHALL abort the operation; no response SHALL be delivered afterwards.
REQ-025 The first accept after reset release SHALL be possible at the first clk edge with rst=0.

Configuration
REQ-026 With macro ARITH_ARB_ROUND_ROBIN_EN defined, a 1-bit pointer SHALL select the preferred requester, and SHALL update to the non-owner on each accept; a lone requester SHALL always win.
REQ-027 Without ARITH_ARB_ROUND_ROBIN_EN, the arbiter SHALL use fixed priority, with requester 0 always winning ties, and SHALL contain no pointer register.

Structure
REQ-028 Package arith_ctrl_pkg SHALL hold the 3-bit opcode localparams (OP_OR..OP_SUB), the FSM state enum type and the DATA_W=8 constant.
REQ-029 The combinational opcode/operand datapath SHALL be the sub-module arith_ctrl_alu; the FSM, arbiter and registers SHALL live in the top.

Verification
REQ-030 Bench SHALL cover: req0 A=8'h0F B=8'h01 op=100 -> rsp_valid_0 two edges after accept, result 8'h10.
REQ-031 Bench SHALL cover: req1 A=8'h0F B=8'h01 op=101 -> 8'h0E; A=8'hAA B=8'hCC op=001 -> 8'h77; op=010 -> 8'h11.
REQ-032 Bench SHALL cover: both valid constantly, op=000 A=8'h0F B=8'hF0 -> with RR_EN grants alternate 0,1,0,1 (each 8'hFF); without it, grants go to 0 only.
REQ-033 Bench SHALL cover: rsp_ready_0 held low for 5 cycles -> rsp_valid_0 and result stay stable, req_ready_1 stays 0, busy=1.
REQ-034 Bench SHALL cover: rst pulsed in EXEC -> outputs 0 immediately, state IDLE, no rsp_valid ever appears for the aborted op.
REQ-035 Bench SHALL cover: op=110 and 8'hFF+8'h01 ADD -> both results 8'h00.
